layer_lane_scheduler: RTL and testbench

- Sequences one layer built from P parallel MVM lanes; each lane computes M/P of the layer's M outputs.
- LOAD phase: broadcasts each N-word input vector to all lanes through an eager fork, so lanes may accept a word in different cycles.
- DRAIN phase: collects lane results in strict round-robin order (lane 0, 1, ..., P-1, 0, ...) into one registered output stream.
- Replaces ad-hoc output muxing in the layer top level; sits between the upstream stream and the lane array.

---
 rtl/layer_lane_scheduler_pkg.sv | 14 +
 rtl/layer_lane_scheduler_lane_fork.sv | 30 +++
 rtl/layer_lane_scheduler.sv | 131 +++++++++++++
 tb/tb_layer_lane_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_lane_scheduler_pkg.sv
// rtl/layer_lane_scheduler_pkg.sv - shared state type and counter width helper
package layer_lane_scheduler_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Width needed to count 0..range_val-1, never less than one bit.
  function automatic int cnt_width(input int range_val);
    return (range_val > 1) ? $clog2(range_val) : 1;
  endfunction

endpackage

// File: rtl/layer_lane_scheduler_lane_fork.sv
// rtl/layer_lane_scheduler_lane_fork.sv - eager broadcast fork; each lane may take the word in a different cycle
module layer_lane_scheduler_lane_fork #(
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         s_valid,
  input  logic [P-1:0] lane_ready,
  output logic [P-1:0] lane_valid,
  output logic         s_ready
);

  // acc[i] marks lanes that already took the current word.
  logic [P-1:0] acc;

  assign lane_valid = {P{enable && s_valid}} & ~acc;
  assign s_ready    = enable && (&(acc | lane_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (s_valid && s_ready) begin
      acc <= '0;
    end else begin
      acc <= acc | (lane_valid & lane_ready);
    end
  end

endmodule

// File: rtl/layer_lane_scheduler.sv
// rtl/layer_lane_scheduler.sv - broadcasts input frames to P lanes, then drains results round-robin
module layer_lane_scheduler
  import layer_lane_scheduler_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8,
  parameter int M = 16,
  parameter int P = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  output logic [P-1:0]   lane_valid,
  input  logic [P-1:0]   lane_ready,
  output logic [W-1:0]   lane_data,
  input  logic [P-1:0]   lane_out_valid,
  output logic [P-1:0]   lane_out_ready,
  input  logic [P*W-1:0] lane_out_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic           busy,
  output logic           frame_done
);

  localparam int IW = cnt_width(N);
  localparam int CW = cnt_width(M + 1);
  localparam int PW = cnt_width(P);

  state_t        state;
  logic [IW-1:0] in_cnt;
  logic [CW-1:0] pop_cnt;
  logic [CW-1:0] out_cnt;
  logic [PW-1:0] ptr;

  logic          accept;
  logic          pop;
  logic          m_fire;
  logic          sel_valid;
  logic [W-1:0]  sel_data;

  layer_lane_scheduler_lane_fork #(
    .P(P)
  ) u_lane_fork (
    .clk        (clk),
    .reset      (reset),
    .enable     (state == LOAD),
    .s_valid    (s_valid),
    .lane_ready (lane_ready),
    .lane_valid (lane_valid),
    .s_ready    (s_ready)
  );

  assign accept    = s_valid && s_ready;
  assign lane_data = s_data;
  assign busy      = (state == DRAIN);
  assign m_fire    = m_valid && m_ready;

  // Only the pointed lane is ever looked at, so results cannot be reordered.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < P; i++) begin
      if (ptr == PW'(i)) begin
        sel_valid = lane_out_valid[i];
        sel_data  = lane_out_data[i*W +: W];
      end
    end
  end

  assign pop = (state == DRAIN) && sel_valid && (!m_valid || m_ready) && (pop_cnt < CW'(M));

  always_comb begin
    lane_out_ready = '0;
    for (int i = 0; i < P; i++) begin
      lane_out_ready[i] = pop && (ptr == PW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      in_cnt     <= '0;
      pop_cnt    <= '0;
      out_cnt    <= '0;
      ptr        <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            if (in_cnt == IW'(N - 1)) begin
              in_cnt <= '0;
              state  <= DRAIN;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop) begin
            m_data  <= sel_data;
            m_valid <= 1'b1;
            ptr     <= (ptr == PW'(P - 1)) ? '0 : ptr + 1'b1;
            pop_cnt <= pop_cnt + 1'b1;
          end else if (m_fire) begin
            m_valid <= 1'b0;
          end
          // The final handshake can never coincide with a pop, as pop_cnt is already M.
          if (m_fire) begin
            if (out_cnt == CW'(M - 1)) begin
              out_cnt    <= '0;
              pop_cnt    <= '0;
              ptr        <= '0;
              state      <= LOAD;
              frame_done <= 1'b1;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_lane_scheduler.sv
// tb/tb_layer_lane_scheduler.sv - self-checking bench for layer_lane_scheduler
module tb_layer_lane_scheduler;
  localparam int W = 16;
  localparam int N = 8;
  localparam int M = 16;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic [P-1:0]   lane_valid;
  logic [P-1:0]   lane_ready;
  logic [W-1:0]   lane_data;
  logic [P-1:0]   lane_out_valid;
  logic [P-1:0]   lane_out_ready;
  logic [P*W-1:0] lane_out_data = '0;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           busy;
  logic           frame_done;

  always #5 clk = ~clk;

  layer_lane_scheduler #(.W(W), .N(N), .M(M), .P(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .lane_valid     (lane_valid),
    .lane_ready     (lane_ready),
    .lane_data      (lane_data),
    .lane_out_valid (lane_out_valid),
    .lane_out_ready (lane_out_ready),
    .lane_out_data  (lane_out_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Behavioural model: frame phase, word/result counts, and a one-deep output holding slot.
  int base [P] = '{100, 200};
  int phase = 0;
  int acc_cnt = 0;
  int out_cnt_m = 0;
  int pops_frame = 0;
  int held = 0;
  int held_val = 0;
  int pending_done = 0;
  int done_pulses = 0;
  int bad_pop = 0;
  int recv [P];
  int lane_pops [P];
  int out_log [$];
  int rx [P][$];

  bit           exp_load;
  bit           exp_sr;
  bit           exp_pop;
  bit [P-1:0]   exp_lv;
  bit [P-1:0]   exp_lor;
  int           pl;

  initial begin
    for (int i = 0; i < P; i++) begin
      recv[i] = 0;
      lane_pops[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      phase = 0; acc_cnt = 0; out_cnt_m = 0; pops_frame = 0;
      held = 0; pending_done = 0;
      out_log.delete();
      for (int i = 0; i < P; i++) begin
        recv[i] = 0;
        lane_pops[i] = 0;
        rx[i].delete();
      end
    end else begin
      exp_load = (phase == 0);
      exp_sr = exp_load;
      for (int i = 0; i < P; i++) begin
        exp_lv[i] = exp_load && s_valid && (recv[i] == acc_cnt);
        if (!(recv[i] > acc_cnt || lane_ready[i])) exp_sr = 1'b0;
      end
      pl = pops_frame % P;
      exp_pop = !exp_load && lane_out_valid[pl] && (held == 0 || m_ready) && (pops_frame < M);
      exp_lor = exp_pop ? (P'(1) << pl) : '0;

      check("busy", busy, !exp_load);
      check("lane_valid", lane_valid, exp_lv);
      check("s_ready", s_ready, exp_sr);
      check("lane_data", lane_data, s_data);
      check("m_valid", m_valid, held);
      if (held == 1) check("m_data", m_data, W'(held_val));
      check("frame_done", frame_done, pending_done);
      check("lane_out_ready", lane_out_ready, exp_lor);
      if (lane_out_ready != 0 && m_valid && !m_ready) bad_pop++;
      if (frame_done) done_pulses++;

      pending_done = 0;
      if (held == 1 && m_ready) begin
        out_log.push_back(held_val);
        held = 0;
        out_cnt_m++;
        if (out_cnt_m == M) begin
          phase = 0; out_cnt_m = 0; pops_frame = 0; pending_done = 1;
        end
      end
      if (exp_pop) begin
        held = 1;
        held_val = base[pl] + lane_pops[pl];
        lane_pops[pl]++;
        pops_frame++;
      end
      for (int i = 0; i < P; i++) begin
        if (exp_lv[i] && lane_ready[i]) begin
          rx[i].push_back(int'(lane_data));
          recv[i]++;
        end
      end
      if (s_valid && exp_sr) begin
        acc_cnt++;
        if (acc_cnt == N) begin
          phase = 1; acc_cnt = 0;
          for (int i = 0; i < P; i++) recv[i] = 0;
        end
      end
    end
  end

  // Bench lanes: each lane's next result is its base plus the number already popped from it.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < P; i++) lane_out_data[i*W +: W] = W'(base[i] + lane_pops[i]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data = W'(w);
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = s_ready;
      step();
    end
    s_valid = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (out_log.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (out_log.size() < n) check("wait_outs_timeout", out_log.size(), n);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_pulses < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", done_pulses, n);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; lane_ready = '0;
    lane_out_valid = '0; m_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready_lanes_busy", s_ready, 0);
    lane_ready = 2'b11;
    #1;
    check("s_ready_without_s_valid", s_ready, 1);
    step();

    // Frame 1: word 5 is taken by lane 0 first, then lane 1.
    for (int w = 1; w <= 4; w++) push(w);
    s_valid = 1'b1; s_data = W'(5); lane_ready = 2'b01;
    @(negedge clk);
    check("w5_c0_s_ready", s_ready, 0);
    check("w5_c0_lane_valid", lane_valid, 2'b11);
    step();
    lane_ready = 2'b10;
    @(negedge clk);
    check("w5_c1_s_ready", s_ready, 1);
    check("w5_c1_lane_valid", lane_valid, 2'b10);
    step();
    lane_ready = 2'b11;
    for (int w = 6; w <= 8; w++) push(w);
    @(negedge clk);
    check("load_end_busy", busy, 1);
    check("load_end_s_ready", s_ready, 0);
    for (int i = 0; i < P; i++)
      for (int k = 0; k < N; k++)
        if (rx[i].size() > k) check($sformatf("lane%0d_word%0d", i, k), rx[i][k], k + 1);
    check("lane0_word_count", rx[0].size(), N);
    check("lane1_word_count", rx[1].size(), N);

    // Lane 1 offers a result first; nothing may come out until lane 0 does.
    step();
    m_ready = 1'b1;
    lane_out_valid = 2'b10;
    repeat (3) step();
    check("lane1_first_held_off", out_log.size(), 0);
    lane_out_valid = 2'b11;
    wait_outs(M);
    wait_done(1);
    repeat (2) step();
    check("single_done_pulse_f1", done_pulses, 1);
    check("f1_back_to_load_busy", busy, 0);
    check("f1_out_count", out_log.size(), M);
    for (int k = 0; k < M; k++)
      if (out_log.size() > k) check($sformatf("f1_out%0d", k), out_log[k], ((k % 2) ? 200 : 100) + k / 2);

    // Frame 2: lane results stay valid during LOAD; m_ready toggles during DRAIN.
    for (int w = 1; w <= N; w++) push(w);
    for (int t = 0; t < 300 && done_pulses < 2; t++) begin
      m_ready = t[0];
      step();
    end
    m_ready = 1'b1;
    check("f2_done_pulses", done_pulses, 2);
    check("f2_out_count", out_log.size(), 2 * M);
    for (int k = 0; k < M; k++)
      if (out_log.size() > M + k) check($sformatf("f2_out%0d", k), out_log[M + k], ((k % 2) ? 208 : 108) + k / 2);
    check("no_pop_while_stalled", bad_pop, 0);

    // Frame 3 is cut off by reset after five outputs.
    for (int w = 1; w <= N; w++) push(w);
    wait_outs(2 * M + 5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_m_valid", m_valid, 0);
    check("mid_reset_busy", busy, 0);
    step();

    // Frame 4 starts fresh.
    for (int w = 1; w <= N; w++) push(w);
    check("f4_lane0_first_word", (rx[0].size() > 0) ? rx[0][0] : -1, 1);
    check("f4_lane0_word_count", rx[0].size(), N);
    wait_done(3);
    check("f4_out_count", out_log.size(), M);
    check("f4_first_out", (out_log.size() > 0) ? out_log[0] : -1, 100);
    check("f4_second_out", (out_log.size() > 1) ? out_log[1] : -1, 200);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
